// File: rtl/ycr_wbb_pkg.sv
// Shared types and helpers for the Wishbone burst bridge.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package ycr_wbb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SREQ,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int unsigned FIFO_DP = 4;
    localparam int unsigned FIFO_PW = $clog2(FIFO_DP);

    function automatic int unsigned min_bl(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ycr_sync_fifo.sv
// Single-clock FIFO of DP entries (DP a power of 2), sync active-high reset.
// Latency: pushed data is visible at dout the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
// Ports: clk/rst; push/din write side; pop/dout read side; full/empty/count status.
module ycr_sync_fifo
    import ycr_wbb_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned DP = FIFO_DP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [W-1:0]         din,
    input  logic                 pop,
    output logic [W-1:0]         dout,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(DP):0]  count
);
    localparam int unsigned PW = $clog2(DP);
    localparam logic [PW:0] DEPTH = DP[PW:0];

    logic [W-1:0]  mem [DP];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is fine when the same cycle frees a slot.
    assign do_push = push & (~full | do_pop);
    // Empty FIFO presents zero so downstream data buses idle at 0.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ycr_wbb_burst_bridge.sv
// Wishbone burst bridge: splits master bursts into slave chunks of at most MAX_SBL beats.
// Latency: write beats acked at once except the last (acked the cycle after the final slave lack); read data >=1 cycle via FIFO.
// Backpressure: write acks stall on full wdata FIFO; wbs_bry_o holds the slave off on empty wdata / full rdata FIFO.
// Ports: wb_clk_i/wb_rst_i; wbm_* master side (bl/lack burst protocol); wbs_* slave side (chunked bursts with bry).
module ycr_wbb_burst_bridge
    import ycr_wbb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned BW      = 4,
    parameter int unsigned BL      = 10,
    parameter int unsigned MAX_SBL = 16,
    parameter int unsigned DP      = FIFO_DP
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbm_stb_i,
    input  logic          wbm_cyc_i,
    input  logic [AW-1:0] wbm_adr_i,
    input  logic          wbm_we_i,
    input  logic [DW-1:0] wbm_dat_i,
    input  logic [BW-1:0] wbm_sel_i,
    input  logic [BL-1:0] wbm_bl_i,
    output logic [DW-1:0] wbm_dat_o,
    output logic          wbm_ack_o,
    output logic          wbm_lack_o,
    output logic          wbm_err_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [AW-1:0] wbs_adr_o,
    output logic          wbs_we_o,
    output logic [BW-1:0] wbs_sel_o,
    output logic [BL-1:0] wbs_bl_o,
    output logic [DW-1:0] wbs_dat_o,
    output logic          wbs_bry_o,
    input  logic [DW-1:0] wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_lack_i,
    input  logic          wbs_err_i
);
    localparam int unsigned PW = $clog2(DP);

    state_t        state_q, state_d;
    logic [AW-1:0] adr_q;
    logic [AW-1:0] step;
    logic          we_q;
    logic [BW-1:0] sel_q;
    logic [BL-1:0] m_cnt, s_rem, chunk, bl_eff;
    logic          err_q, wack_q, werr_q;
    logic          active, in_sreq, m_req, start;
    logic          s_beat, s_last, last_chunk;
    logic          wr_ack, wr_final, rd_ack, m_dec;
    logic          wf_push, wf_pop, wf_full, wf_empty;
    logic [DW-1:0] wf_dout;
    logic [PW:0]   wf_count;
    logic          rf_push, rf_full, rf_empty;
    logic [DW:0]   rf_dout;
    logic [PW:0]   rf_count;

    assign bl_eff     = (wbm_bl_i == '0) ? BL'(1) : wbm_bl_i;
    assign active     = (state_q != ST_IDLE);
    assign in_sreq    = (state_q == ST_SREQ);
    assign m_req      = wbm_stb_i & wbm_cyc_i;
    assign start      = (state_q == ST_IDLE) & m_req;
    assign s_beat     = in_sreq & (wbs_ack_i | wbs_err_i);
    assign s_last     = s_beat & wbs_lack_i;
    assign last_chunk = (s_rem == chunk);
    assign step       = AW'(chunk) * AW'(BW);

    // All but the last write beat are acked as they enter the FIFO; the last is
    // taken silently so its ack can carry the burst's final error status.
    assign wr_ack   = active & we_q & m_req & (m_cnt > BL'(1)) & ~wf_full;
    assign wr_final = active & we_q & m_req & (m_cnt == BL'(1)) & ~wf_full;
    assign rd_ack   = active & ~we_q & m_req & ~rf_empty;
    assign m_dec    = wr_ack | wr_final | rd_ack;

    assign wf_push = wr_ack | wr_final;
    assign wf_pop  = we_q & s_beat;
    assign rf_push = ~we_q & s_beat;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (m_req) state_d = ST_SREQ;
            ST_SREQ: if (s_last) state_d = last_chunk ? ST_DONE : ST_GAP;
            ST_GAP:  state_d = ST_SREQ;
            ST_DONE: if (m_cnt == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            adr_q  <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            m_cnt  <= '0;
            s_rem  <= '0;
            chunk  <= '0;
            err_q  <= 1'b0;
            wack_q <= 1'b0;
            werr_q <= 1'b0;
        end else begin
            // Final write ack is issued once the last chunk has fully landed.
            wack_q <= we_q & s_last & last_chunk;
            werr_q <= we_q & s_last & last_chunk & (err_q | wbs_err_i);
            if (start) begin
                adr_q <= wbm_adr_i;
                we_q  <= wbm_we_i;
                sel_q <= wbm_sel_i;
                m_cnt <= bl_eff;
                s_rem <= bl_eff;
                chunk <= BL'(min_bl(32'(bl_eff), MAX_SBL));
                err_q <= 1'b0;
            end else begin
                if (m_dec) m_cnt <= m_cnt - 1'b1;
                if (s_beat & wbs_err_i) err_q <= 1'b1;
                if (s_last) begin
                    s_rem <= s_rem - chunk;
                    adr_q <= adr_q + step;
                end
                if (state_q == ST_GAP) chunk <= BL'(min_bl(32'(s_rem), MAX_SBL));
            end
        end
    end

    ycr_sync_fifo #(.W(DW), .DP(DP)) u_wfifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (wf_push),
        .din   (wbm_dat_i),
        .pop   (wf_pop),
        .dout  (wf_dout),
        .full  (wf_full),
        .empty (wf_empty),
        .count (wf_count)
    );

    ycr_sync_fifo #(.W(DW + 1), .DP(DP)) u_rfifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (rf_push),
        .din   ({wbs_err_i, wbs_dat_i}),
        .pop   (rd_ack),
        .dout  (rf_dout),
        .full  (rf_full),
        .empty (rf_empty),
        .count (rf_count)
    );

    assign wbs_cyc_o = in_sreq;
    assign wbs_stb_o = in_sreq;
    assign wbs_adr_o = adr_q;
    assign wbs_we_o  = we_q;
    assign wbs_sel_o = sel_q;
    assign wbs_bl_o  = chunk;
    assign wbs_dat_o = wf_dout;
    assign wbs_bry_o = in_sreq & (we_q ? ~wf_empty : ~rf_full);

    assign wbm_dat_o  = rf_dout[DW-1:0];
    assign wbm_ack_o  = we_q ? (wr_ack | wack_q) : rd_ack;
    assign wbm_lack_o = wack_q | (rd_ack & (m_cnt == BL'(1)));
    assign wbm_err_o  = (wack_q & werr_q) | (rd_ack & rf_dout[DW]);

    a_ack_needs_bry: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        s_beat |-> wbs_bry_o);
    a_fifo_bound: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        (32'(wf_count) <= DP) && (32'(rf_count) <= DP));

endmodule

// File: tb/tb_ycr_wbb_burst_bridge.sv
module tb_ycr_wbb_burst_bridge;
    localparam int DP      = 4;
    localparam int MAX_SBL = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbm_stb_i, wbm_cyc_i, wbm_we_i;
    logic [31:0] wbm_adr_i, wbm_dat_i;
    logic [3:0]  wbm_sel_i;
    logic [9:0]  wbm_bl_i;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_o, wbm_lack_o, wbm_err_o;
    logic        wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_bry_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic [3:0]  wbs_sel_o;
    logic [9:0]  wbs_bl_o;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_i, wbs_lack_i, wbs_err_i;

    always #5 wb_clk_i = ~wb_clk_i;

    ycr_wbb_burst_bridge #(.AW(32), .DW(32), .BW(4), .BL(10), .MAX_SBL(MAX_SBL), .DP(DP)) dut (
        .wb_clk_i (wb_clk_i),  .wb_rst_i (wb_rst_i),
        .wbm_stb_i(wbm_stb_i), .wbm_cyc_i(wbm_cyc_i), .wbm_adr_i(wbm_adr_i),
        .wbm_we_i (wbm_we_i),  .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_bl_i (wbm_bl_i),  .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o),
        .wbm_lack_o(wbm_lack_o), .wbm_err_o(wbm_err_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_adr_o(wbs_adr_o),
        .wbs_we_o (wbs_we_o),  .wbs_sel_o(wbs_sel_o), .wbs_bl_o (wbs_bl_o),
        .wbs_dat_o(wbs_dat_o), .wbs_bry_o(wbs_bry_o), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_i(wbs_ack_i), .wbs_lack_i(wbs_lack_i), .wbs_err_i(wbs_err_i)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        wbm_stb_i = 1'b0; wbm_cyc_i = 1'b0;
        wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_lack_i = 1'b0; wbs_dat_i = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge wb_clk_i); #1;
            clear_inputs();
        end
    endtask

    // One master burst against a behavioural slave. Expected chunking, data
    // order, ack/lack/err placement all come from the burst rules directly.
    task automatic burst(input logic we, input logic [31:0] adr, input logic [9:0] bl,
                         input logic [3:0] sel, input int ack_pct, input int drop_pct,
                         input int err_beat, input int hold, input int abort_at);
        int          n, macks, sbeats, ci, cbeat, gap, c, slack_c, mlack_c;
        bit          in_chunk, done, exp_err, err_now;
        logic [31:0] wd[];
        logic [32:0] rd_exp[$];
        logic [31:0] exp_cadr[$];
        int          exp_clen[$];
        n = (bl == 0) ? 1 : int'(bl);
        wd = new[n];
        foreach (wd[i]) wd[i] = $urandom;
        exp_err = (err_beat >= 0) && (err_beat < n);
        for (int off = 0; off < n; off += MAX_SBL) begin
            exp_cadr.push_back(adr + 32'(off * 4));
            exp_clen.push_back((n - off < MAX_SBL) ? n - off : MAX_SBL);
        end
        macks = 0; sbeats = 0; ci = 0; cbeat = 0; gap = 0; c = 0;
        slack_c = 0; mlack_c = 0; in_chunk = 0; done = 0;
        while (!done && c < 3000) begin
            @(posedge wb_clk_i); #1;
            wbm_we_i = we; wbm_adr_i = adr; wbm_sel_i = sel; wbm_bl_i = bl;
            if (c == 0)                               wbm_stb_i = 1'b1;
            else if (hold > 0 && c >= 2 && c < 2 + hold) wbm_stb_i = 1'b0;
            else wbm_stb_i = ($urandom_range(0, 99) >= drop_pct);
            wbm_cyc_i = wbm_stb_i;
            wbm_dat_i = wd[(macks < n) ? macks : n - 1];
            wbs_ack_i = 0; wbs_err_i = 0; wbs_lack_i = 0; wbs_dat_i = '0;
            if (wbs_stb_o) begin
                if (!in_chunk) begin
                    in_chunk = 1; cbeat = 0;
                    if (ci > 0) chk("gap_len", gap, 1);
                    gap = 0;
                    if (ci < exp_cadr.size()) begin
                        chk("chunk_adr", wbs_adr_o, exp_cadr[ci]);
                        chk("chunk_bl", wbs_bl_o, exp_clen[ci]);
                    end else chk("extra_chunk", ci, exp_cadr.size());
                    chk("chunk_we_sel", {wbs_we_o, wbs_sel_o}, {we, sel});
                    ci++;
                end
                if (wbs_bry_o && $urandom_range(0, 99) < ack_pct) begin
                    err_now = (sbeats == err_beat);
                    wbs_ack_i = !err_now; wbs_err_i = err_now;
                    wbs_lack_i = (cbeat + 1 == int'(wbs_bl_o));
                    if (we) chk("wdat", wbs_dat_o, (sbeats < n) ? wd[sbeats] : 32'h0);
                    else begin
                        wbs_dat_i = $urandom;
                        rd_exp.push_back({err_now, wbs_dat_i});
                    end
                    sbeats++; cbeat++;
                    if (wbs_lack_i) begin in_chunk = 0; slack_c = c; end
                end
            end else if (ci > 0) gap++;
            if (hold > 0 && c == 1 + hold) begin
                chk("stall_fill", sbeats, DP);
                chk("stall_bry", wbs_bry_o, 0);
            end
            #1;
            if (wbm_ack_o) begin
                if (we) chk("werr", wbm_err_o, (macks == n - 1) && exp_err);
                else if (rd_exp.size() > 0) chk("rdat", {wbm_err_o, wbm_dat_o}, rd_exp.pop_front());
                else chk("rd_underflow", 1, 0);
                chk("lack", wbm_lack_o, macks == n - 1);
                macks++;
                if (wbm_lack_o || macks >= n) begin done = 1; mlack_c = c; end
                if (abort_at > 0 && macks == abort_at) return;
            end
            c++;
        end
        if (!done) chk("timeout", 1, 0);
        chk("m_acks", macks, n);
        chk("s_beats", sbeats, n);
        chk("n_chunks", ci, exp_cadr.size());
        if (we && done) chk("wack_lat", mlack_c - slack_c, 1);
        idle(3);
    endtask

    initial begin
        wb_rst_i = 1'b1;
        clear_inputs();
        wbm_we_i = 0; wbm_adr_i = '0; wbm_sel_i = '0; wbm_bl_i = '0; wbm_dat_i = '0;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        chk("rst_ctl", {wbm_ack_o, wbm_lack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o,
                        wbs_we_o, wbs_bry_o, wbs_sel_o, wbs_bl_o}, 0);
        chk("rst_adr_dat", {wbs_adr_o, wbs_dat_o}, 0);
        chk("rst_mdat", wbm_dat_o, 0);

        // Directed cases.
        burst(1'b1, 32'h100, 10'd1, 4'hF, 100, 0, -1, 0, 0);
        burst(1'b0, 32'h0, 10'd40, 4'hF, 100, 0, -1, 0, 0);
        burst(1'b0, 32'h200, 10'd64, 4'hF, 100, 0, -1, 30, 0);
        burst(1'b1, 32'h300, 10'd8, 4'h3, 100, 0, 2, 0, 0);

        // Reset in the middle of a read burst, then a clean write.
        burst(1'b0, 32'h400, 10'd20, 4'hF, 100, 0, -1, 0, 5);
        @(posedge wb_clk_i); #1;
        clear_inputs();
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        chk("rst_mid_ctl", {wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbs_bry_o}, 0);
        chk("rst_mid_fifo", {wbm_dat_o, wbs_dat_o}, 0);
        burst(1'b1, 32'h500, 10'd2, 4'hF, 100, 0, -1, 0, 0);

        // bl=0 and address wrap / exact multiples of the chunk size.
        burst(1'b1, 32'h600, 10'd0, 4'hF, 100, 0, -1, 0, 0);
        burst(1'b0, 32'h700, 10'd0, 4'hF, 100, 0, -1, 0, 0);
        burst(1'b0, 32'hFFFF_FFFC, 10'd32, 4'hF, 100, 0, -1, 0, 0);
        burst(1'b1, 32'h800, 10'd16, 4'hF, 70, 0, 15, 0, 0);

        // Randomized bursts with slave and master throttling.
        for (int k = 0; k < 16; k++) begin
            int bl_r, eb;
            bl_r = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 120) : $urandom_range(0, 40);
            eb   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (bl_r > 0) ? bl_r - 1 : 0) : -1;
            burst($urandom_range(0, 1) == 1, {$urandom, 2'b00} & 32'hFFFF_FFFC, 10'(bl_r),
                  4'($urandom), $urandom_range(30, 100), $urandom_range(0, 30), eb, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
